// File: rtl/sha1_pad_writer.sv
// SHA-1 padding writer: appends the 0x80 marker, zero fill and the 64-bit
// big-endian bit length to a message already resident in the shared DPSRAM.
module sha1_pad_writer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start_pad,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       message_size,
    output logic              done,
    output logic              error,
    output logic [31:0]       padded_size,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_RD_ISSUE, S_RD_WAIT, S_WR_PAD,
        S_ZERO, S_LEN_HI, S_LEN_LO, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       msg_addr_q, msg_addr_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       padded_q, padded_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [5:0]        rem_s;
    logic [31:0]       base_s;
    logic [31:0]       word_inc_s;
    logic [31:0]       last_word_s;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Lanes below the first free byte keep memory contents, the marker goes
    // into the first free lane and everything above is cleared.
    function automatic logic [31:0] pad_word(input logic [31:0] rd, input logic [1:0] lane);
        logic [31:0] w;
        case (lane)
            2'd0:    w = 32'h0000_0080;
            2'd1:    w = {16'h0000, 8'h80, rd[7:0]};
            2'd2:    w = {8'h00, 8'h80, rd[15:0]};
            2'd3:    w = {8'h80, rd[23:0]};
            default: w = 32'h0000_0080;
        endcase
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return ADDR_W'(base + (idx << 2));
    endfunction

    assign word_inc_s  = word_q + 32'd1;
    assign last_word_s = len_q >> 2;

    // Pad base: the length field starts at byte 56 of the block that can still
    // hold the marker, otherwise of the following block.
    always_comb begin
        rem_s = len_q[5:0] + 6'd1;
        if ((rem_s >= 6'd1) && (rem_s <= 6'd56)) begin
            base_s = {len_q[31:6], 6'd0} + 32'd56;
        end else begin
            base_s = {len_q[31:6], 6'd0} + 32'd120;
        end
    end

    // Next-state and next-output logic; outputs are loaded together with the
    // state they belong to, so the memory port sees them during that state.
    always_comb begin
        state_d    = state_q;
        msg_addr_d = msg_addr_q;
        len_d      = len_q;
        word_d     = word_q;
        done_d     = 1'b0;
        error_d    = error_q;
        padded_d   = padded_q;
        we_d       = 1'b0;
        a_addr_d   = a_addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_pad) begin
                    state_d    = S_CALC;
                    msg_addr_d = message_addr;
                    len_d      = message_size;
                    error_d    = 1'b0;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_CALC: begin
                word_d = last_word_s;
                if (msg_addr_q[1:0] != 2'b00) begin
                    state_d  = S_FIN;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    padded_d = base_s + 32'd8;
                end else if (len_q[1:0] == 2'b00) begin
                    state_d  = S_WR_PAD;
                    a_addr_d = word_addr(msg_addr_q, last_word_s);
                    we_d     = 1'b1;
                    wdata_d  = 32'h0000_0080;
                end else begin
                    state_d  = S_RD_ISSUE;
                    a_addr_d = word_addr(msg_addr_q, last_word_s);
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_d = S_WR_PAD;
                we_d    = 1'b1;
                wdata_d = pad_word(port_A_data_out, len_q[1:0]);
            end
            S_WR_PAD, S_ZERO: begin
                word_d   = word_inc_s;
                a_addr_d = word_addr(msg_addr_q, word_inc_s);
                we_d     = 1'b1;
                if (word_inc_s == (base_s >> 2)) begin
                    state_d = S_LEN_HI;
                    wdata_d = bswap32({29'd0, len_q[31:29]});
                end else begin
                    state_d = S_ZERO;
                    wdata_d = 32'h0000_0000;
                end
            end
            S_LEN_HI: begin
                state_d  = S_LEN_LO;
                word_d   = word_inc_s;
                a_addr_d = word_addr(msg_addr_q, word_inc_s);
                we_d     = 1'b1;
                wdata_d  = bswap32({len_q[28:0], 3'b000});
            end
            S_LEN_LO: begin
                state_d  = S_FIN;
                done_d   = 1'b1;
                error_d  = 1'b0;
                padded_d = base_s + 32'd8;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            msg_addr_q <= 32'd0;
            len_q      <= 32'd0;
            word_q     <= 32'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            padded_q   <= 32'd0;
            we_q       <= 1'b0;
            a_addr_q   <= {ADDR_W{1'b0}};
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            msg_addr_q <= msg_addr_d;
            len_q      <= len_d;
            word_q     <= word_d;
            done_q     <= done_d;
            error_q    <= error_d;
            padded_q   <= padded_d;
            we_q       <= we_d;
            a_addr_q   <= a_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign port_A_clk     = clk;
    assign port_A_addr    = a_addr_q;
    assign port_A_we      = we_q;
    assign port_A_data_in = wdata_q;
    assign done           = done_q;
    assign error          = error_q;
    assign padded_size    = padded_q;

endmodule

// File: tb/tb_sha1_pad_writer.sv
// Randomised scoreboard bench for sha1_pad_writer: a byte-level padding model
// predicts every memory write and each done; a monitor compares them.
module tb_sha1_pad_writer;

    localparam int ADDR_W = 16;
    localparam int NW     = 1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              nreset;
    logic              start_pad;
    logic [31:0]       message_addr;
    logic [31:0]       message_size;
    logic              done;
    logic              error;
    logic [31:0]       padded_size;
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic              port_A_we;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out;

    always #5 clk = ~clk;

    sha1_pad_writer #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .start_pad      (start_pad),
        .message_addr   (message_addr),
        .message_size   (message_size),
        .done           (done),
        .error          (error),
        .padded_size    (padded_size),
        .port_A_clk     (port_A_clk),
        .port_A_addr    (port_A_addr),
        .port_A_we      (port_A_we),
        .port_A_data_in (port_A_data_in),
        .port_A_data_out(port_A_data_out)
    );

    // Synchronous DPSRAM model with one-cycle read latency.
    logic [31:0] mem [NW];
    logic [31:0] init_mem [NW];
    logic        load_en;
    logic [31:0] rd_q;

    always @(posedge port_A_clk) begin
        if (load_en) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_mem[i];
        end else if (port_A_we) begin
            mem[port_A_addr[ADDR_W-1:2]] <= port_A_data_in;
        end
        rd_q <= mem[port_A_addr[ADDR_W-1:2]];
    end
    assign port_A_data_out = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endfunction

    typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic err; logic chk_size; logic [31:0] size; int lat; } dn_t;
    wr_t exp_wr[$];
    dn_t exp_dn[$];
    int  start_cyc = 0;
    int  done_cnt  = 0;
    logic done_prev = 1'b0;
    wr_t mon_w;
    dn_t mon_d;

    // Reference: build the padded byte stream (message, 0x80, zeros up to
    // 56 mod 64, 8-byte big-endian bit count) and pack it little-endian.
    task automatic push_expect(input logic [31:0] a, input logic [31:0] len);
        logic [31:0] p;
        logic [63:0] bitlen;
        logic [31:0] data;
        logic [7:0]  b;
        logic [31:0] n;
        logic [31:0] wa;
        if (a[1:0] != 2'b00) begin
            exp_dn.push_back('{err: 1'b1, chk_size: 1'b0, size: 32'd0, lat: 2});
            return;
        end
        p = len + 32'd1;
        while ((p % 32'd64) != 32'd56) p = p + 32'd1;
        p = p + 32'd8;
        bitlen = {32'd0, len} << 3;
        for (logic [31:0] w = len / 32'd4; w < p / 32'd4; w++) begin
            data = 32'd0;
            for (int k = 0; k < 4; k++) begin
                n = 32'd4 * w + 32'(k);
                if (n < len) begin
                    wa = (a + 32'd4 * w) & 32'((1 << ADDR_W) - 1);
                    b  = 8'(init_mem[wa >> 2] >> (8 * k));
                end else if (n == len) begin
                    b = 8'h80;
                end else if (n < p - 32'd8) begin
                    b = 8'h00;
                end else begin
                    b = 8'(bitlen >> (8 * (7 - int'(n - (p - 32'd8)))));
                end
                data = data | (32'(b) << (8 * k));
            end
            exp_wr.push_back('{addr: ADDR_W'(a + 32'd4 * w), data: data});
        end
        exp_dn.push_back('{err: 1'b0, chk_size: 1'b1, size: p,
                           lat: 2 + int'(p / 32'd4 - len / 32'd4) + ((len % 32'd4 != 32'd0) ? 2 : 0)});
    endtask

    // Monitor: compares every write and every done against the queues.
    always @(negedge clk) begin
        if (nreset) begin
            if (port_A_we) begin
                if (exp_wr.size() == 0) begin
                    fail_now("unexpected_write", $sformatf("got write addr 0x%04h, expected none", port_A_addr));
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", 32'(port_A_addr), 32'(mon_w.addr));
                    check("wr_data", port_A_data_in, mon_w.data);
                end
            end
            if (done_prev) check("done_pulse_width", 32'(done), 32'd0);
            if (done) begin
                if (exp_dn.size() == 0) begin
                    fail_now("unexpected_done", "got done, expected none");
                end else begin
                    mon_d = exp_dn.pop_front();
                    check("error", 32'(error), 32'(mon_d.err));
                    if (mon_d.chk_size) check("padded_size", padded_size, mon_d.size);
                    check("latency", 32'(cyc - start_cyc + 1), 32'(mon_d.lat));
                    check("missing_writes", 32'(exp_wr.size()), 32'd0);
                end
                done_cnt = done_cnt + 1;
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic fill_random();
        for (int i = 0; i < NW; i++) init_mem[i] = $urandom;
    endtask

    task automatic commit_mem();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] len);
        push_expect(a, len);
        @(negedge clk);
        message_addr = a;
        message_size = len;
        start_pad    = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start_pad = 1'b0;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] len);
        int tgt;
        tgt = done_cnt + 1;
        issue(a, len);
        for (int i = 0; i < 3000 && done_cnt < tgt; i++) @(posedge clk);
        if (done_cnt < tgt) begin
            fail_now("timeout", $sformatf("no done within 3000 cycles, expected one (L=%0d)", len));
            exp_wr.delete();
            exp_dn.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_mem(input int idx, input logic [31:0] exp);
        check($sformatf("mem[%0d]", idx), mem[idx], exp);
    endtask

    initial begin
        nreset       = 1'b0;
        start_pad    = 1'b0;
        message_addr = 32'd0;
        message_size = 32'd0;
        load_en      = 1'b0;
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_padded_size", padded_size, 32'd0);
        check("rst_we", 32'(port_A_we), 32'd0);
        check("rst_addr", 32'(port_A_addr), 32'd0);
        check("rst_data_in", port_A_data_in, 32'd0);
        @(negedge clk);
        nreset = 1'b1;

        fill_random(); commit_mem();
        run(32'd0, 32'd120);
        chk_mem(30, 32'h0000_0080); chk_mem(45, 32'd0);
        chk_mem(46, 32'd0); chk_mem(47, 32'hC003_0000);

        fill_random(); init_mem[0] = 32'h0123_4567; commit_mem();
        run(32'd0, 32'd3);
        chk_mem(0, 32'h8023_4567); chk_mem(14, 32'd0); chk_mem(15, 32'h1800_0000);

        fill_random(); commit_mem();
        run(32'd0, 32'd55);
        chk_mem(15, 32'hB801_0000);

        fill_random(); commit_mem();
        run(32'd0, 32'd56);
        chk_mem(31, 32'hC001_0000);

        fill_random(); commit_mem();
        run(32'd0, 32'd0);
        chk_mem(0, 32'h0000_0080); chk_mem(15, 32'd0);

        run(32'd2, 32'd40);

        // Abort in the middle of the zero fill, then redo the transfer.
        fill_random(); commit_mem();
        issue(32'd0, 32'd120);
        repeat (6) @(posedge clk);
        #3 nreset = 1'b0;
        #1;
        check("abort_we", 32'(port_A_we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_wr.delete();
        exp_dn.delete();
        @(negedge clk);
        nreset = 1'b1;
        fill_random(); commit_mem();
        run(32'd0, 32'd120);
        chk_mem(30, 32'h0000_0080); chk_mem(47, 32'hC003_0000);

        for (int t = 0; t < 20; t++) begin
            logic [31:0] a;
            logic [31:0] len;
            len = 32'($urandom_range(0, 300));
            a   = 32'($urandom_range(0, 16'h3000)) << 2;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            fill_random(); commit_mem();
            run(a, len);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
